// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button front end.
package btn_pkg;

  localparam int BTN_START   = 0;
  localparam int BTN_PAUSE   = 1;
  localparam int BTN_SUB_SEC = 4;
  localparam int BTN_ADD_MIN = 5;
  localparam int BTN_MODE    = 7;

  // add/subtract buttons auto-repeat while held
  localparam logic [7:0] REPEAT_MASK_DEFAULT = 8'b0011_0000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_FIRST,
    RPT_PERIOD
  } rpt_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, counter debouncer, optional auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1, s2, lvl;
  logic [CW-1:0] cnt;
  logic          accept, rise, fall;

  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_fire;

  assign lvl    = ~s2;
  assign accept = (lvl != pressed) && (cnt == DB_LAST);
  assign rise   = accept & lvl;
  assign fall   = accept & ~lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      pressed       <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (lvl == pressed) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        pressed <= lvl;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press_pulse   <= rise | rep_fire;
      release_pulse <= fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REPEAT_EN ? RPT_FIRST : RPT_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // A release wins over a due repeat, so no pulse lands in the release cycle.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rep_fire = 1'b0;
    if (!REPEAT_EN) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else if (fall) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else if (rise) begin
      state_d = RPT_FIRST;
      rcnt_d  = '0;
    end else if (pressed) begin
      unique case (state_q)
        RPT_FIRST: begin
          if (rcnt_q == RD_LAST) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
            state_d  = RPT_PERIOD;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT_PERIOD: begin
          if (rcnt_q == RP_LAST) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: N_BTN independent synchronise/debounce/repeat channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 8,
  parameter int               DEBOUNCE_CYCLES = 2,
  parameter int               REPEAT_DELAY    = 8,
  parameter int               REPEAT_PERIOD   = 4,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: expected pulse events are queued when buttons are driven.
module tb_btn_conditioner;

  typedef struct {
    int         at;
    logic [7:0] pp;
    logic [7:0] rp;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [7:0] pressed, press_pulse, release_pulse;

  ev_t        sb[$];
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         k, r;
  logic [15:0] mon_exp;

  btn_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [7:0] pp, input logic [7:0] rp);
    ev_t e;
    e.at = at;
    e.pp = pp;
    e.rp = rp;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Every cycle: pulses must match the queued event for this edge, else be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        mon_exp = {sb[0].pp, sb[0].rp};
        void'(sb.pop_front());
      end
      chk("pulses", {16'h0, press_pulse, release_pulse}, {16'h0, mon_exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    btn = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_pressed", pressed, 0);
    chk("rst_pulses", {press_pulse, release_pulse}, 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_pressed", pressed, 0);

    // single press/release on start
    k = cyc + 1;
    btn = 8'hFE;
    push(k + 3, 8'h01, 8'h00);
    wait_edge(k + 2);
    chk("t2_pre_rise", pressed, 8'h00);
    wait_edge(k + 3);
    chk("t2_rise", pressed, 8'h01);
    wait_edge(k + 9);
    btn = 8'hFF;
    k = cyc + 1;
    push(k + 3, 8'h00, 8'h01);
    wait_edge(k + 2);
    chk("t2_pre_fall", pressed, 8'h01);
    wait_edge(k + 3);
    chk("t2_fall", pressed, 8'h00);
    wait_edge(k + 10);

    // one-cycle glitch on pause
    k = cyc + 1;
    btn = 8'hFD;
    @(negedge clk);
    btn = 8'hFF;
    wait_edge(k + 10);
    chk("t3_glitch", pressed, 8'h00);

    // auto-repeat on add_min
    k = cyc + 1;
    btn = 8'hDF;
    push(k + 3, 8'h20, 8'h00);
    for (int i = 11; i <= 31; i += 4) push(k + i, 8'h20, 8'h00);
    wait_edge(k + 29);
    chk("t4_held", pressed, 8'h20);
    btn = 8'hFF;
    push(k + 33, 8'h00, 8'h20);
    wait_edge(k + 45);

    // start, pause and mode together, none of which repeat
    k = cyc + 1;
    btn = 8'h7C;
    push(k + 3, 8'h83, 8'h00);
    wait_edge(k + 20);
    chk("t5_held", pressed, 8'h83);
    btn = 8'hFF;
    k = cyc + 1;
    push(k + 3, 8'h00, 8'h83);
    wait_edge(k + 10);

    // reset in the middle of a repeat sequence on sub_sec
    k = cyc + 1;
    btn = 8'hEF;
    push(k + 3,  8'h10, 8'h00);
    push(k + 11, 8'h10, 8'h00);
    push(k + 15, 8'h10, 8'h00);
    wait_edge(k + 17);
    rst = 1'b1;
    wait_edge(k + 18);
    r = cyc;
    rst = 1'b0;
    chk("t6_rst_pressed", pressed, 8'h00);
    push(r + 4,  8'h10, 8'h00);
    push(r + 12, 8'h10, 8'h00);
    push(r + 16, 8'h10, 8'h00);
    wait_edge(r + 3);
    chk("t6_pre_repress", pressed, 8'h00);
    wait_edge(r + 4);
    chk("t6_repress", pressed, 8'h10);
    wait_edge(r + 16);
    // release lands exactly where the next repeat would have been due
    btn = 8'hFF;
    push(r + 20, 8'h00, 8'h10);
    wait_edge(r + 30);
    chk("t6_released", pressed, 8'h00);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
